// File: rtl/wb_arbiter.sv
// Write-back arbiter for a single register-file write port.
// The ALU path has a fixed one-cycle latency and always wins the port.
// The long-latency (LSU/mul/div) path is buffered in a 2-entry FIFO and
// drains whenever the ALU is silent. A 32-bit scoreboard tracks registers
// with an outstanding long-latency write.
module wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid_in,
    input  logic [4:0]  alu_rd_addr_in,
    input  logic [31:0] alu_rd_data_in,
    input  logic        lsu_valid_in,
    output logic        lsu_ready_out,
    input  logic [4:0]  lsu_rd_addr_in,
    input  logic [31:0] lsu_rd_data_in,
    input  logic        issue_valid_in,
    input  logic [4:0]  issue_rd_in,
    input  logic [4:0]  rs1_addr_in,
    input  logic [4:0]  rs2_addr_in,
    output logic        rs1_busy_out,
    output logic        rs2_busy_out,
    output logic        alu_stall_out,
    output logic        rd_we_out,
    output logic [4:0]  rd_addr_out,
    output logic [31:0] rd_data_out
);

    // LSU buffer storage and pointers
    logic [4:0]  fifo_addr_q [2];
    logic [31:0] fifo_data_q [2];
    logic        rptr_q, rptr_d;
    logic        wptr_q, wptr_d;
    logic [1:0]  count_q, count_d;

    // Scoreboard of registers awaiting a long-latency write
    logic [31:0] busy_q, busy_d;

    // Registered write port
    logic        rd_we_q, rd_we_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_data_q, rd_data_d;

    logic        push;
    logic        pop;
    logic [4:0]  head_addr;
    logic [31:0] head_data;

    assign lsu_ready_out = (count_q != 2'd2);
    assign alu_stall_out = (count_q == 2'd2);

    assign head_addr = fifo_addr_q[rptr_q];
    assign head_data = fifo_data_q[rptr_q];

    assign rs1_busy_out = (rs1_addr_in != '0) && busy_q[rs1_addr_in];
    assign rs2_busy_out = (rs2_addr_in != '0) && busy_q[rs2_addr_in];

    assign rd_we_out   = rd_we_q;
    assign rd_addr_out = rd_addr_q;
    assign rd_data_out = rd_data_q;

    // Port selection, FIFO bookkeeping and scoreboard update
    always_comb begin
        push      = lsu_valid_in && lsu_ready_out;
        pop       = !alu_valid_in && (count_q != 2'd0);
        rd_we_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        busy_d    = busy_q;
        rptr_d    = rptr_q;
        wptr_d    = wptr_q;
        count_d   = count_q;

        if (alu_valid_in) begin
            rd_we_d   = (alu_rd_addr_in != '0);
            rd_addr_d = alu_rd_addr_in;
            rd_data_d = alu_rd_data_in;
        end else if (pop) begin
            rd_we_d   = (head_addr != '0);
            rd_addr_d = head_addr;
            rd_data_d = head_data;
        end

        // The entry being written this edge releases its register; a
        // same-edge issue to that register is applied afterwards so it wins.
        if (pop && (head_addr != '0)) begin
            busy_d[head_addr] = 1'b0;
        end
        if (issue_valid_in && (issue_rd_in != '0)) begin
            busy_d[issue_rd_in] = 1'b1;
        end

        if (pop) begin
            rptr_d = ~rptr_q;
        end
        if (push) begin
            wptr_d = ~wptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Control, scoreboard and write-port registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr_q    <= 1'b0;
            wptr_q    <= 1'b0;
            count_q   <= '0;
            busy_q    <= '0;
            rd_we_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            rd_we_q   <= rd_we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // FIFO storage; written only on an accepted LSU transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else if (push) begin
            fifo_addr_q[wptr_q] <= lsu_rd_addr_in;
            fifo_data_q[wptr_q] <= lsu_rd_data_in;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model.
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid_in;
    logic [4:0]  alu_rd_addr_in;
    logic [31:0] alu_rd_data_in;
    logic        lsu_valid_in;
    logic        lsu_ready_out;
    logic [4:0]  lsu_rd_addr_in;
    logic [31:0] lsu_rd_data_in;
    logic        issue_valid_in;
    logic [4:0]  issue_rd_in;
    logic [4:0]  rs1_addr_in;
    logic [4:0]  rs2_addr_in;
    logic        rs1_busy_out;
    logic        rs2_busy_out;
    logic        alu_stall_out;
    logic        rd_we_out;
    logic [4:0]  rd_addr_out;
    logic [31:0] rd_data_out;

    wb_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid_in   (alu_valid_in),
        .alu_rd_addr_in (alu_rd_addr_in),
        .alu_rd_data_in (alu_rd_data_in),
        .lsu_valid_in   (lsu_valid_in),
        .lsu_ready_out  (lsu_ready_out),
        .lsu_rd_addr_in (lsu_rd_addr_in),
        .lsu_rd_data_in (lsu_rd_data_in),
        .issue_valid_in (issue_valid_in),
        .issue_rd_in    (issue_rd_in),
        .rs1_addr_in    (rs1_addr_in),
        .rs2_addr_in    (rs2_addr_in),
        .rs1_busy_out   (rs1_busy_out),
        .rs2_busy_out   (rs2_busy_out),
        .alu_stall_out  (alu_stall_out),
        .rd_we_out      (rd_we_out),
        .rd_addr_out    (rd_addr_out),
        .rd_data_out    (rd_data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    bit          mbusy[32];
    bit          exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;

    int unsigned n_vec;
    int unsigned n_err;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
    endtask

    // One clock edge of the reference behaviour
    task automatic model_edge(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                              input bit lv, input logic [4:0] la, input logic [31:0] ld,
                              input bit iv, input logic [4:0] ir);
        bit   room;
        ent_t e;
        room = (mq.size() < 2);
        if (av) begin
            exp_we   = (aa != 0);
            exp_addr = aa;
            exp_data = ad;
        end else if (mq.size() > 0) begin
            e        = mq.pop_front();
            exp_we   = (e.a != 0);
            exp_addr = e.a;
            exp_data = e.d;
            mbusy[e.a] = 1'b0;
        end else begin
            exp_we = 1'b0;
        end
        if (lv && room) mq.push_back('{a: la, d: ld});
        if (iv && ir != 0) mbusy[ir] = 1'b1;
    endtask

    // Apply one cycle of inputs; check combinational outputs, then the edge result
    task automatic cyc(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit lv, input logic [4:0] la, input logic [31:0] ld,
                       input bit iv, input logic [4:0] ir,
                       input logic [4:0] r1, input logic [4:0] r2);
        alu_valid_in   = av;
        alu_rd_addr_in = aa;
        alu_rd_data_in = ad;
        lsu_valid_in   = lv;
        lsu_rd_addr_in = la;
        lsu_rd_data_in = ld;
        issue_valid_in = iv;
        issue_rd_in    = ir;
        rs1_addr_in    = r1;
        rs2_addr_in    = r2;
        #1;
        check_eq("lsu_ready", 64'(lsu_ready_out), 64'(mq.size() < 2));
        check_eq("alu_stall", 64'(alu_stall_out), 64'(mq.size() == 2));
        check_eq("rs1_busy", 64'(rs1_busy_out), 64'(r1 != 0 && mbusy[r1]));
        check_eq("rs2_busy", 64'(rs2_busy_out), 64'(r2 != 0 && mbusy[r2]));
        @(posedge clk);
        model_edge(av, aa, ad, lv, la, ld, iv, ir);
        #1;
        check_eq("rd_we", 64'(rd_we_out), 64'(exp_we));
        check_eq("rd_addr", 64'(rd_addr_out), 64'(exp_addr));
        check_eq("rd_data", 64'(rd_data_out), 64'(exp_data));
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_we"},    64'(rd_we_out), 64'(0));
        check_eq({tag, "_addr"},  64'(rd_addr_out), 64'(0));
        check_eq({tag, "_data"},  64'(rd_data_out), 64'(0));
        check_eq({tag, "_ready"}, 64'(lsu_ready_out), 64'(1));
        check_eq({tag, "_stall"}, 64'(alu_stall_out), 64'(0));
        check_eq({tag, "_rs1"},   64'(rs1_busy_out), 64'(0));
        check_eq({tag, "_rs2"},   64'(rs2_busy_out), 64'(0));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        rst            = 1'b0;
        alu_valid_in   = 1'b0;
        alu_rd_addr_in = '0;
        alu_rd_data_in = '0;
        lsu_valid_in   = 1'b0;
        lsu_rd_addr_in = '0;
        lsu_rd_data_in = '0;
        issue_valid_in = 1'b0;
        issue_rd_in    = '0;
        rs1_addr_in    = 5'd3;
        rs2_addr_in    = 5'd4;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");

        // Inputs must be ignored while reset is held
        alu_valid_in   = 1'b1;
        alu_rd_addr_in = 5'd5;
        alu_rd_data_in = 32'hCAFE0001;
        lsu_valid_in   = 1'b1;
        lsu_rd_addr_in = 5'd3;
        issue_valid_in = 1'b1;
        issue_rd_in    = 5'd3;
        @(posedge clk);
        #1;
        check_reset_outputs("inrst");
        alu_valid_in   = 1'b0;
        lsu_valid_in   = 1'b0;
        issue_valid_in = 1'b0;
        #2 rst = 1'b1;

        // ALU single write, then idle drops the enable
        cyc(1, 5, 32'h12345678, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0);

        // Long-latency write clears its busy bit
        cyc(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        idle(7, 0);
        cyc(0, 0, 0, 1, 7, 32'hDEADBEEF, 0, 0, 7, 0);
        idle(7, 7);
        idle(7, 7);

        // FIFO fills under ALU priority, then drains in order
        cyc(1, 1, 32'h11, 1, 10, 32'hA, 0, 0, 10, 11);
        cyc(1, 2, 32'h22, 1, 11, 32'hB, 0, 0, 10, 11);
        cyc(1, 3, 32'h33, 1, 12, 32'hC, 0, 0, 10, 11);
        idle(10, 11);
        idle(10, 11);
        idle(10, 11);

        // Address 0 never enables the write
        cyc(0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
        idle(0, 0);
        cyc(1, 0, 32'h55AA55AA, 0, 0, 0, 1, 0, 0, 0);
        idle(0, 0);

        // Set wins over same-edge clear
        cyc(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        cyc(0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        idle(9, 0);
        idle(9, 0);

        // Mid-operation asynchronous reset
        cyc(0, 0, 0, 0, 0, 0, 1, 3, 3, 4);
        cyc(0, 0, 0, 0, 0, 0, 1, 4, 3, 4);
        cyc(1, 6, 32'h600D0001, 1, 3, 32'h33333333, 0, 0, 3, 4);
        cyc(1, 8, 32'h600D0002, 1, 4, 32'h44444444, 0, 0, 3, 4);
        alu_valid_in = 1'b0;
        lsu_valid_in = 1'b0;
        rs1_addr_in  = 5'd3;
        rs2_addr_in  = 5'd4;
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("async");
        model_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        idle(3, 4);
        idle(3, 4);
        idle(3, 4);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit          av, lv, iv;
            logic [4:0]  aa, la, ir, r1, r2;
            logic [31:0] ad, ld;
            av = ($urandom_range(0, 99) < 40);
            lv = ($urandom_range(0, 99) < 55);
            iv = ($urandom_range(0, 99) < 30);
            aa = 5'($urandom_range(0, 7));
            la = 5'($urandom_range(0, 7));
            ir = 5'($urandom_range(0, 7));
            r1 = 5'($urandom_range(0, 7));
            r2 = 5'($urandom_range(0, 31));
            ad = $urandom;
            ld = $urandom;
            cyc(av, aa, ad, lv, la, ld, iv, ir, r1, r2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 alu_valid_in  in  1  single-cycle result present this cycle; no ready, always consumed.
REQ-004 alu_rd_addr_in  in  5  destination register of ALU result.
REQ-005 alu_rd_data_in  in  32  ALU result value.
REQ-006 lsu_valid_in  in  1  long-latency (load/mul/div) result offered.
REQ-007 lsu_ready_out  out  1  buffer can accept; transfer when lsu_valid_in && lsu_ready_out at rising edge.
REQ-008 lsu_rd_addr_in  in  5  destination register of LSU result.
REQ-009 lsu_rd_data_in  in  32  LSU result value.
REQ-010 issue_valid_in  in  1  long-latency op issued this cycle; marks its rd busy.
REQ-011 issue_rd_in  in  5  destination of issued long-latency op.
REQ-012 rs1_addr_in / rs2_addr_in  in  5 each  source operands being decoded.
REQ-013 rs1_busy_out / rs2_busy_out  out  1 each  operand has a pending long-latency write.
REQ-014 alu_stall_out  out  1  upstream shall hold ALU results; asserted when buffer full.
REQ-015 rd_we_out  out  1  register-file write enable, registered.
REQ-016 rd_addr_out  out  5  register-file write address, registered.
REQ-017 rd_data_out  out  32  register-file write data, registered.

Function
REQ-018 LSU path shall use a 2-entry FIFO {addr, data}; lsu_ready_out = (count < 2), combinational from count only.
REQ-019 Each edge, write-port select: ALU if alu_valid_in; else FIFO head if count > 0 (pop); else idle.
REQ-020 ALU result at edge N shall appear on rd_*_out after edge N (1-cycle latency).
REQ-021 LSU result accepted at edge N shall appear on rd_*_out no earlier than after edge N+1; no bypass.
REQ-022 Push and pop in same edge shall be allowed; count unchanged; FIFO order strictly preserved.
REQ-023 rd_we_out shall be 1 only when a source is selected and its address != 0; address-0 entries still pop, rd_addr_out/rd_data_out still update.
REQ-024 When idle, rd_we_out = 0; rd_addr_out/rd_data_out hold previous values.
REQ-025 alu_stall_out = (count == 2), combinational; ALU retains priority even if alu_valid_in violates stall (no data loss in FIFO, ALU written).
REQ-026 Scoreboard: 32 busy bits; issue_valid_in with issue_rd_in != 0 sets busy[issue_rd_in] at edge.
REQ-027 Busy bit cleared at the edge where an LSU entry with matching address is selected for write.
REQ-028 Same-edge set and clear of same register: set wins (busy stays 1).
REQ-029 rsX_busy_out = busy[rsX_addr_in], combinational; forced 0 for address 0; x0 never marked busy.
REQ-030 ALU writes shall not affect busy bits.

Reset
REQ-031 rst low shall immediately force: FIFO count 0, all busy bits 0, rd_we_out 0, rd_addr_out 0, rd_data_out 0.
REQ-032 During reset lsu_ready_out = 1, alu_stall_out = 0, rsX_busy_out = 0; inputs ignored.
REQ-033 Reset mid-operation shall discard buffered LSU entries and pending busy bits without any write-port pulse.

Verification
REQ-034 alu_valid_in=1, addr=5, data=0x12345678 at edge N -> after N: rd_we_out=1, rd_addr_out=5, rd_data_out=0x12345678; next idle cycle rd_we_out=0.
REQ-035 issue rd=7; later LSU push addr=7 data=0xDEADBEEF with no ALU -> rs1_busy_out=1 for rs1=7 until write edge; rd_we_out=1 addr 7 one cycle after accept, busy cleared same edge.
REQ-036 ALU valid every cycle while LSU pushes 0xA, 0xB -> count reaches 2, lsu_ready_out=0, alu_stall_out=1; ALU drops -> 0xA then 0xB written on consecutive cycles.
REQ-037 LSU push addr=0 data=0xFFFFFFFF -> entry pops, rd_we_out stays 0; ALU addr=0 likewise no write.
REQ-038 FIFO holding 2 entries, busy bits set for r3,r4; assert rst low mid-cycle -> outputs 0 asynchronously, after release no writes, rs busy all 0.
REQ-039 issue rd=9 same edge as LSU entry rd=9 written -> busy[9] remains 1.
